// File: rtl/wb_mem_port_arbiter.sv
// Single data-memory write port shared by buffered WB-stage stores and an external loader.
// WB stores queue in a small FIFO that MEM-stage loads can snoop; the loader is burst-capped.
module wb_mem_port_arbiter #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int DEPTH         = 4,
    parameter int LDR_MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_we,
    input  logic [AW-1:0]                wb_addr,
    input  logic [DW-1:0]                wb_data,
    output logic                         pipe_stall,
    input  logic                         ldr_req,
    input  logic [AW-1:0]                ldr_addr,
    input  logic [DW-1:0]                ldr_data,
    output logic                         ldr_gnt,
    input  logic [AW-1:0]                rd_addr,
    output logic                         rd_hit,
    output logic [DW-1:0]                rd_data,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_data,
    output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(LDR_MAX_BURST+1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef enum logic [1:0] {IDLE, LDR, WB} state_t;

    state_t                 state, state_nxt;
    wr_t    [DEPTH-1:0]     fifo;
    logic   [PW-1:0]        head, tail;
    logic   [CW-1:0]        count;
    logic   [BW-1:0]        burst_cnt, burst_nxt;
    logic                   empty, full, wb_idle;
    logic                   gnt_ldr, gnt_wb, bypass, push, pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign wb_idle = empty && !wb_we;

    // Grants are masked while reset is asserted so no handshake leaks out.
    always_comb begin
        gnt_ldr   = 1'b0;
        gnt_wb    = 1'b0;
        state_nxt = IDLE;
        burst_nxt = '0;
        if (rst && ldr_req && (burst_cnt < BW'(LDR_MAX_BURST) || wb_idle)) begin
            gnt_ldr   = 1'b1;
            state_nxt = LDR;
            burst_nxt = (burst_cnt == BW'(LDR_MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
        end else if (rst && (!empty || wb_we)) begin
            gnt_wb    = 1'b1;
            state_nxt = WB;
        end
    end

    assign bypass     = gnt_wb && empty;
    assign pop        = gnt_wb && !empty;
    assign pipe_stall = full && !gnt_wb;
    assign push       = wb_we && !pipe_stall && !bypass;
    assign ldr_gnt    = gnt_ldr;
    assign buf_count  = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // The state is the last grant, so it doubles as the registered write enable.
    assign mem_we = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (gnt_ldr) begin
            mem_addr <= ldr_addr;
            mem_data <= ldr_data;
        end else if (gnt_wb) begin
            mem_addr <= bypass ? wb_addr : fifo[head].addr;
            mem_data <= bypass ? wb_data : fifo[head].data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity comes from count.
    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= '{addr: wb_addr, data: wb_data};
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        rd_hit  = 1'b0;
        rd_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && fifo[idx].addr == rd_addr) begin
                rd_hit  = 1'b1;
                rd_data = fifo[idx].data;
            end
        end
        if (bypass && wb_addr == rd_addr) begin
            rd_hit  = 1'b1;
            rd_data = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Directed bench for wb_mem_port_arbiter: queue-based model checked every cycle,
// plus literal expectations for the bypass, fairness, full, snoop and reset scenarios.
module tb_wb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wb_we = 1'b0;
    logic [7:0] wb_addr = '0, wb_data = '0;
    logic       pipe_stall;
    logic       ldr_req = 1'b0;
    logic [7:0] ldr_addr = '0, ldr_data = '0;
    logic       ldr_gnt;
    logic [7:0] rd_addr = 8'hFF;
    logic       rd_hit;
    logic [7:0] rd_data;
    logic       mem_we;
    logic [7:0] mem_addr, mem_data;
    logic [2:0] buf_count;

    always #5 clk = ~clk;

    wb_mem_port_arbiter #(.AW(8), .DW(8), .DEPTH(4), .LDR_MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .pipe_stall(pipe_stall),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_gnt(ldr_gnt),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .buf_count(buf_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending stores as a queue, registered write as three variables.
    typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t       mq[$];
    int         mbc = 0;
    logic       mwe = 1'b0;
    logic [7:0] maddr = '0, mdata = '0;

    always @(negedge clk) begin
        logic gl, gw, st, byp, eh;
        logic [7:0] ed;
        ent_t e;
        if (!rst) begin
            mq.delete();
            mbc = 0; mwe = 1'b0; maddr = '0; mdata = '0;
            check("rst_mem_we",   mem_we,     0);
            check("rst_mem_addr", mem_addr,   0);
            check("rst_mem_data", mem_data,   0);
            check("rst_ldr_gnt",  ldr_gnt,    0);
            check("rst_stall",    pipe_stall, 0);
            check("rst_rd_hit",   rd_hit,     0);
            check("rst_rd_data",  rd_data,    0);
            check("rst_count",    buf_count,  0);
        end else begin
            gl  = ldr_req && (mbc < 8 || (mq.size() == 0 && !wb_we));
            gw  = !gl && (mq.size() != 0 || wb_we);
            st  = (mq.size() == 4) && !gw;
            byp = gw && mq.size() == 0;
            eh = 1'b0; ed = '0;
            foreach (mq[i]) if (mq[i].a == rd_addr) begin eh = 1'b1; ed = mq[i].d; end
            if (byp && wb_addr == rd_addr) begin eh = 1'b1; ed = wb_data; end
            check("ldr_gnt",    ldr_gnt,    gl);
            check("pipe_stall", pipe_stall, st);
            check("rd_hit",     rd_hit,     eh);
            check("rd_data",    rd_data,    ed);
            check("buf_count",  buf_count,  mq.size());
            check("mem_we",     mem_we,     mwe);
            if (mwe) begin
                check("mem_addr", mem_addr, maddr);
                check("mem_data", mem_data, mdata);
            end
            if (gl) begin
                mwe = 1'b1; maddr = ldr_addr; mdata = ldr_data;
                if (mbc < 8) mbc++;
            end else if (gw) begin
                mwe = 1'b1; mbc = 0;
                if (byp) begin maddr = wb_addr; mdata = wb_data; end
                else begin e = mq.pop_front(); maddr = e.a; mdata = e.d; end
            end else begin
                mwe = 1'b0; mbc = 0;
            end
            if (wb_we && !st && !byp) mq.push_back('{wb_addr, wb_data});
        end
    end

    logic [7:0] wlog[$];
    int         stall_cycles = 0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) wlog.push_back(mem_addr);
        if (pipe_stall === 1'b1) stall_cycles++;
    end

    // All drivers start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_store(input logic [7:0] a, input logic [7:0] d);
        logic st;
        int k;
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        for (k = 0; k < 100; k++) begin
            @(negedge clk); st = pipe_stall;
            @(posedge clk); #1;
            if (!st) break;
        end
        if (k == 100) check("wb_store_timeout", 1, 0);
        wb_we = 1'b0;
    endtask

    task automatic ldr_write(input logic [7:0] a, input logic [7:0] d);
        logic g;
        int k;
        ldr_req = 1'b1; ldr_addr = a; ldr_data = d;
        for (k = 0; k < 100; k++) begin
            @(negedge clk); g = ldr_gnt;
            @(posedge clk); #1;
            if (g) break;
        end
        if (k == 100) check("ldr_write_timeout", 1, 0);
        ldr_req = 1'b0;
    endtask

    task automatic ldr_burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) ldr_write(base + 8'(i), 8'hC0 + 8'(i));
    endtask

    initial begin
        int s, s0;
        longint t0;
        logic [7:0] wbseq[$];

        // Power-on reset state
        @(negedge clk);
        check("por_mem_we", mem_we, 0);
        check("por_count",  buf_count, 0);
        @(posedge clk); #1 rst = 1'b1;
        idle(2);

        // Bypass straight to memory
        rd_addr = 8'h10;
        wb_store(8'h10, 8'hA5);
        rd_addr = 8'hFF;
        @(negedge clk);
        check("byp_mem_we",   mem_we,    1);
        check("byp_mem_addr", mem_addr,  8'h10);
        check("byp_mem_data", mem_data,  8'hA5);
        check("byp_count",    buf_count, 0);
        idle(2);

        // Loader alone: back-to-back grants
        s = wlog.size();
        t0 = $time;
        ldr_burst(3, 8'h90);
        check("ldr_alone_cycles", 32'(($time - t0) / 10), 3);
        idle(3);
        check("ldr_alone_writes", wlog.size() - s, 3);
        check("ldr_alone_w0", wlog[s],   8'h90);
        check("ldr_alone_w2", wlog[s+2], 8'h92);

        // Fairness: 8 loader, 1 WB, 8 loader, 1 WB, then drain
        s = wlog.size();
        fork
            ldr_burst(20, 8'h80);
            for (int i = 0; i < 4; i++) wb_store(8'h20 + 8'(i), 8'h40 + 8'(i));
        join
        idle(4);
        check("fair_writes", wlog.size() - s, 24);
        check("fair_pos8",   wlog[s+8],  8'h20);
        check("fair_pos17",  wlog[s+17], 8'h21);
        check("fair_pos22",  wlog[s+22], 8'h22);
        check("fair_pos23",  wlog[s+23], 8'h23);
        check("fair_pos7",   wlog[s+7],  8'h87);

        // Full FIFO under loader pressure: forced WB grant does push+pop
        s  = wlog.size();
        s0 = stall_cycles;
        fork
            ldr_burst(12, 8'hA0);
            for (int i = 0; i < 6; i++) wb_store(8'h50 + 8'(i), 8'h60 + 8'(i));
        join
        idle(8);
        check("full_stall_cycles", stall_cycles - s0, 8);
        wbseq.delete();
        for (int i = s; i < wlog.size(); i++)
            if (wlog[i] >= 8'h50 && wlog[i] <= 8'h55) wbseq.push_back(wlog[i]);
        check("full_wb_count", wbseq.size(), 6);
        for (int i = 0; i < 6 && i < wbseq.size(); i++)
            check("full_wb_order", wbseq[i], 8'h50 + 8'(i));
        check("full_drained", buf_count, 0);

        // Snoop: youngest match wins
        fork
            ldr_burst(8, 8'hB0);
            begin
                wb_store(8'h30, 8'h11);
                wb_store(8'h31, 8'h22);
                wb_store(8'h30, 8'h33);
                rd_addr = 8'h30;
                @(negedge clk);
                check("snoop_hit",   rd_hit,    1);
                check("snoop_data",  rd_data,   8'h33);
                check("snoop_count", buf_count, 3);
                @(posedge clk); #1 rd_addr = 8'h40;
                @(negedge clk);
                check("snoop_miss_hit",  rd_hit,  0);
                check("snoop_miss_data", rd_data, 0);
            end
        join
        rd_addr = 8'hFF;
        idle(6);

        // Reset mid-burst with three entries pending
        ldr_req = 1'b1; ldr_addr = 8'h70; ldr_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            wb_we = 1'b1; wb_addr = 8'h60 + 8'(i); wb_data = 8'h01 + 8'(i);
            @(posedge clk); #1;
        end
        wb_we = 1'b0;
        @(negedge clk);
        check("pre_rst_count", buf_count, 3);
        @(posedge clk); #1;
        rst = 1'b0; ldr_req = 1'b0;
        #1;
        check("async_rst_mem_we", mem_we, 0);
        check("async_rst_count",  buf_count, 0);
        @(posedge clk); #1 rst = 1'b1;
        s = wlog.size();
        idle(4);
        check("no_stale_write", wlog.size() - s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
